// File: rtl/round_timer_if.sv
// -----------------------------------------------------------------------------
// round_timer_if
// Control/display bundle between the round timer and its surroundings.
//
//   Tick       1  one-cycle 1 Hz strobe from the rate divider
//   Start      1  one-cycle pulse: load start value and begin counting
//   Pause      1  level: freeze the countdown while high
//   OnesDigit  4  ones BCD digit (HEX0)
//   TensDigit  4  tens BCD digit (HEX1)
//   Running    1  high while counting
//   Expired    1  high while the count sits at 00
//   TimeUp     1  one-cycle pulse when the count reaches 00
//   Warn       1  low-time indicator (zero unless ROUND_TIMER_WARN_EN)
//   Blank      1  display blink request (zero unless ROUND_TIMER_WARN_EN)
//
// master: the controller side that drives Tick/Start/Pause.
// slave : the timer itself.
// -----------------------------------------------------------------------------
interface round_timer_if;
    logic       Tick;
    logic       Start;
    logic       Pause;
    logic [3:0] OnesDigit;
    logic [3:0] TensDigit;
    logic       Running;
    logic       Expired;
    logic       TimeUp;
    logic       Warn;
    logic       Blank;

    modport master (
        output Tick, Start, Pause,
        input  OnesDigit, TensDigit, Running, Expired, TimeUp, Warn, Blank
    );

    modport slave (
        input  Tick, Start, Pause,
        output OnesDigit, TensDigit, Running, Expired, TimeUp, Warn, Blank
    );
endinterface

// File: rtl/round_timer.sv
// -----------------------------------------------------------------------------
// round_timer
// Two-digit BCD countdown timer for a game round. Start loads the configured
// start value and begins counting down one second per Tick; Pause freezes the
// count; reaching 00 parks the timer in EXPIRED and emits a single TimeUp.
//
// Parameters
//   START_TENS  tens BCD digit loaded on Start (0-9)
//   START_ONES  ones BCD digit loaded on Start (0-9)
//
// Ports
//   ClockIn  system clock (50 MHz)
//   Reset    synchronous, active-high reset
//   bus      round_timer_if.slave: Tick/Start/Pause in; digits and status out
//
// Optional feature (macro ROUND_TIMER_WARN_EN)
//   Defined  : Warn is high while running/paused below ten seconds (count
//              nonzero); Blank toggles on every accepted Tick while Warn is
//              high, so the hex stage can blink the display.
//   Undefined: Warn and Blank are tied low and no warn logic exists.
// -----------------------------------------------------------------------------
module round_timer #(
    parameter int unsigned START_TENS = 6,
    parameter int unsigned START_ONES = 0
) (
    input  logic           ClockIn,
    input  logic           Reset,
    round_timer_if.slave   bus
);

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] START_T   = DIGIT_W'(START_TENS);
    localparam logic [DIGIT_W-1:0] START_O   = DIGIT_W'(START_ONES);
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);
    localparam logic [DIGIT_W-1:0] DIGIT_0   = DIGIT_W'(0);
    localparam logic [DIGIT_W-1:0] DIGIT_1   = DIGIT_W'(1);
    localparam bit                 START_ZERO = (START_TENS == 0) && (START_ONES == 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [DIGIT_W-1:0] r_tens;
    logic [DIGIT_W-1:0] r_ones;
    logic [DIGIT_W-1:0] w_tens_next;
    logic [DIGIT_W-1:0] w_ones_next;
    logic               r_running;
    logic               r_expired;
    logic               r_time_up;
    logic               w_time_up_next;

    // State, digits and status flags
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_tens    <= START_T;
            r_ones    <= START_O;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_time_up <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_tens    <= w_tens_next;
            r_ones    <= w_ones_next;
            r_running <= (w_state_next == S_RUN);
            r_expired <= (w_state_next == S_EXPIRED);
            r_time_up <= w_time_up_next;
        end
    end

    // Next state, next digits and TimeUp; Start outranks Tick and Pause
    always_comb begin
        w_state_next   = r_state;
        w_tens_next    = r_tens;
        w_ones_next    = r_ones;
        w_time_up_next = 1'b0;

        if (bus.Start) begin
            w_tens_next = START_T;
            w_ones_next = START_O;
            if (START_ZERO) begin
                // Restarting an already-expired timer at 00 must not re-pulse TimeUp
                w_state_next   = S_EXPIRED;
                w_time_up_next = (r_state != S_EXPIRED);
            end else if (bus.Pause) begin
                w_state_next = S_PAUSED;
            end else begin
                w_state_next = S_RUN;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.Pause) begin
                        w_state_next = S_PAUSED;
                    end else if (bus.Tick) begin
                        // BCD borrow: ones wraps to 9 and takes one from tens
                        if (r_ones != DIGIT_0) begin
                            w_ones_next = r_ones - DIGIT_1;
                        end else if (r_tens != DIGIT_0) begin
                            w_ones_next = DIGIT_MAX;
                            w_tens_next = r_tens - DIGIT_1;
                        end
                        if ((w_tens_next == DIGIT_0) && (w_ones_next == DIGIT_0)) begin
                            w_state_next   = S_EXPIRED;
                            w_time_up_next = 1'b1;
                        end
                    end
                end
                S_PAUSED: begin
                    if (!bus.Pause) begin
                        w_state_next = S_RUN;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    assign bus.TensDigit = r_tens;
    assign bus.OnesDigit = r_ones;
    assign bus.Running   = r_running;
    assign bus.Expired   = r_expired;
    assign bus.TimeUp    = r_time_up;

`ifdef ROUND_TIMER_WARN_EN
    logic r_warn;
    logic r_blank;
    logic w_warn_next;
    logic w_blank_next;
    logic w_tick_accept;

    // Warn/Blank follow the next count so they line up with the digits they describe
    always_comb begin
        w_tick_accept = (r_state == S_RUN) && !bus.Start && !bus.Pause && bus.Tick;
        w_warn_next   = ((w_state_next == S_RUN) || (w_state_next == S_PAUSED)) &&
                        (w_tens_next == DIGIT_0) && (w_ones_next != DIGIT_0);
        w_blank_next  = r_blank;
        if (bus.Start || !w_warn_next) begin
            w_blank_next = 1'b0;
        end else if (w_tick_accept && r_warn) begin
            // Only ticks taken while already warning blink the display
            w_blank_next = !r_blank;
        end
    end

    // Warn/Blank registers
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_warn  <= 1'b0;
            r_blank <= 1'b0;
        end else begin
            r_warn  <= w_warn_next;
            r_blank <= w_blank_next;
        end
    end

    assign bus.Warn  = r_warn;
    assign bus.Blank = r_blank;
`else
    assign bus.Warn  = 1'b0;
    assign bus.Blank = 1'b0;
`endif

endmodule

// File: doc/round_timer.md
ROUND_TIMER -- requirements
Module: round_timer

Interface
REQ-001 Parameter START_TENS, default 6: tens BCD digit loaded on Start; legal range 0-9.
REQ-002 Parameter START_ONES, default 0: ones BCD digit loaded on Start; legal range 0-9.
REQ-003 ClockIn  input  1  system clock (50 MHz).
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of ClockIn.
REQ-005 Tick  input  1  one-cycle 1 Hz strobe from the rate divider.
REQ-006 Start  input  1  one-cycle pulse that loads START value and begins the countdown.
REQ-007 Pause  input  1  level; freezes the countdown while high.
REQ-008 OnesDigit  output  4  ones BCD digit, feeds the hex decoder for HEX0.
REQ-009 TensDigit  output  4  tens BCD digit, feeds the hex decoder for HEX1.
REQ-010 Running  output  1  high while in RUN.
REQ-011 Expired  output  1  level, high while in EXPIRED.
REQ-012 TimeUp  output  1  one-cycle pulse on entry to EXPIRED.
REQ-013 Warn  output  1  low-time indicator (see Configuration).
REQ-014 Blank  output  1  display blank request for the hex stage (see Configuration).

Function
REQ-015 FSM states: IDLE, RUN, PAUSED, EXPIRED; all outputs registered.
REQ-016 IDLE: digits hold START value; Start -> RUN if Pause low, PAUSED if Pause high.
REQ-017 RUN: Pause high -> PAUSED next cycle, Tick in that same cycle ignored.
REQ-018 RUN: Tick with Pause low -> BCD decrement by one second, new digits visible the cycle after Tick.
REQ-019 Decrement: ones>0 -> ones-1; ones==0 -> ones=9, tens-1; digits never leave 0-9.
REQ-020 RUN: decrement producing 00 -> EXPIRED in the same edge; TimeUp high exactly that following cycle.
REQ-021 PAUSED: digits frozen, Ticks ignored; Pause low -> RUN next cycle.
REQ-022 EXPIRED: digits hold 00, Expired high; Tick and Pause ignored.
REQ-023 Start in any state reloads START value; Start has priority over Tick and Pause-driven transitions in the same cycle.
REQ-024 Start with START value 00 -> EXPIRED directly, TimeUp pulses once.
REQ-025 Tick and Start in same cycle: digits = START value, no decrement applied.
REQ-026 TimeUp never asserts for two consecutive cycles; Start in EXPIRED does not re-pulse TimeUp unless the count again reaches 00.

Reset
REQ-027 Reset -> state IDLE, TensDigit=START_TENS, OnesDigit=START_ONES, Running=0, Expired=0, TimeUp=0, Warn=0, Blank=0.
REQ-028 Reset has priority over Start, Tick and Pause; Reset mid-countdown abandons the count with no TimeUp.

Configuration
REQ-029 Macro ROUND_TIMER_WARN_EN defined: Warn high in RUN or PAUSED when TensDigit==0 and count nonzero.
REQ-030 With ROUND_TIMER_WARN_EN: Blank toggles on every accepted Tick while Warn high; Blank cleared when Warn falls, on Start, on Reset.
REQ-031 Without ROUND_TIMER_WARN_EN: Warn and Blank tied to 0, ports still present, no warn logic synthesized.

Verification
REQ-032 Reset, Start, 60 Ticks (spaced 5 cycles) -> digits 60,59,...,01,00; TimeUp one pulse after 60th Tick; Expired=1, Running=0.
REQ-033 Count at 40, Tick -> 39 (ones wrap 0->9, tens 4->3); at 10, Tick -> 09.
REQ-034 At 25, Pause high for 3 Ticks -> stays 25, state PAUSED; Pause low then Tick -> 24.
REQ-035 At 12, Start and Tick same cycle -> 60, RUN; at 00/EXPIRED, Start -> 60, RUN, Expired=0.
REQ-036 Reset asserted at 07 in RUN -> 60, IDLE, TimeUp never pulses; further Ticks leave 60.
REQ-037 WARN_EN build: at 10 Tick -> 09, Warn=1; each later Tick toggles Blank; at 00 Warn=0, Blank=0; non-WARN build: Warn=Blank=0 throughout.
